// File: rtl/seg7_display_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_display_ctrl: N-digit 7-segment controller with bus-written digits,  |
// | hex/raw decode, blink, leading-zero blanking and message override.        |
// | Optional PWM dimming: define SEG7_DIM_EN.                                 |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module seg7_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  parameter int BLINK_DIV = 25_000_000,
  parameter logic [7*NUM_DIGITS-1:0] MSG = '0
`ifdef SEG7_DIM_EN
  ,
  parameter int PWM_BITS = 4
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [8:0]              wr_data,
  input  logic [AW-1:0]           rd_addr,
  output logic [8:0]              rd_data,
  input  logic                    lz_suppress,
  input  logic                    msg_force,
  output logic                    blink_phase,
`ifdef SEG7_DIM_EN
  input  logic [PWM_BITS-1:0]     brightness,
`endif
  output logic [7*NUM_DIGITS-1:0] seg_n
);

  localparam int c_bw = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_bw-1:0] c_blink_last = c_bw'(BLINK_DIV - 1);

  logic [8:0]              r_digit [NUM_DIGITS];
  logic [8:0]              w_rd;
  logic                    r_lz;
  logic                    r_msg;
  logic [c_bw-1:0]         r_blink_cnt;
  logic [NUM_DIGITS-1:0]   w_lz_blank;
  logic                    w_chain;
  logic                    w_lit_en;
  logic [7*NUM_DIGITS-1:0] w_seg_next;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h3F;  4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;  4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;  4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;  4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;  4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;  4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;  4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;  default: hex_glyph = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (wr_en && wr_addr == AW'(i)) r_digit[i] <= wr_data;
    end
  end

  // Out-of-range addresses match no digit and read back as zero.
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (rd_addr == AW'(i)) w_rd = r_digit[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data     <= '0;
      r_lz        <= 1'b0;
      r_msg       <= 1'b0;
      r_blink_cnt <= '0;
      blink_phase <= 1'b0;
    end else begin
      rd_data <= w_rd;
      r_lz    <= lz_suppress;
      r_msg   <= msg_force;
      if (r_blink_cnt == c_blink_last) begin
        r_blink_cnt <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Chain stays set while every digit seen so far (from the top) is a hex zero.
  always_comb begin
    w_chain    = r_lz;
    w_lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (r_digit[i][7] || r_digit[i][3:0] != 4'd0) w_chain = 1'b0;
      if (i != 0) w_lz_blank[i] = w_chain;
    end
  end

`ifdef SEG7_DIM_EN
  logic [PWM_BITS-1:0] r_pwm_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pwm_cnt <= '0;
    else       r_pwm_cnt <= r_pwm_cnt + 1'b1;
  end

  assign w_lit_en = (r_pwm_cnt < brightness);
`else
  assign w_lit_en = 1'b1;
`endif

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
      logic [6:0] w_lit;
      logic [6:0] w_show;

      always_comb begin
        w_lit = r_digit[gi][7] ? r_digit[gi][6:0] : hex_glyph(r_digit[gi][3:0]);
        if (r_msg)                              w_show = MSG[7*gi +: 7];
        else if (r_digit[gi][8] && blink_phase) w_show = '0;
        else if (w_lz_blank[gi])                w_show = '0;
        else                                    w_show = w_lit;
      end

      assign w_seg_next[7*gi +: 7] = ~(w_show & {7{w_lit_en}});
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) seg_n <= '1;
    else       seg_n <= w_seg_next;
  end

endmodule
`default_nettype wire
